// File: rtl/vga_timing_gen_if.sv
// Timing bundle from vga_timing_gen to the pixel/framebuffer stage.
// Carries frame_count only when VGA_TIMING_FRAME_CNT_EN is defined.
interface vga_timing_gen_if;
  logic       pixel_ce;
  logic [9:0] hcount;
  logic [9:0] vcount;
  logic       hsync;
  logic       vsync;
  logic       active;
  logic       line_start;
  logic       frame_start;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [7:0] frame_count;
`endif

  modport master (
    output pixel_ce, hcount, vcount, hsync, vsync, active, line_start, frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
    , output frame_count
`endif
  );

  modport slave (
    input pixel_ce, hcount, vcount, hsync, vsync, active, line_start, frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
    , input frame_count
`endif
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA 640x480@60 timing generator running off the PLL clock with a pixel clock-enable.
// Optional 8-bit frame counter output when VGA_TIMING_FRAME_CNT_EN is defined.
module vga_timing_gen #(
  parameter int CLK_DIV   = 4,
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int SYNC_POL  = 0
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             pll_locked,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  // 11-bit bounds so a window ending exactly at 1024 still compares correctly
  localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
  localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic        SYNC_ON  = (SYNC_POL != 0);

  if (H_TOTAL > 1024) begin : g_h_total_chk
    $error("vga_timing_gen: H_TOTAL exceeds 1024");
  end
  if (V_TOTAL > 1024) begin : g_v_total_chk
    $error("vga_timing_gen: V_TOTAL exceeds 1024");
  end
  if (CLK_DIV < 2) begin : g_div_chk
    $error("vga_timing_gen: CLK_DIV must be at least 2");
  end

  logic [1:0]       sync_q;
  logic             run;
  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       h_q, h_d;
  logic [9:0]       v_q, v_d;
  logic             pce;
  logic             line_start;
  logic             frame_start;

  // Lock synchronizer: only reset clears it, so lock loss just drains through
  always_ff @(posedge clock_in) begin
    if (!reset) sync_q <= '0;
    else        sync_q <= {sync_q[0], pll_locked};
  end

  assign run = sync_q[1];
  assign pce = run && (div_q == DIV_LAST);

  always_comb begin
    div_d = div_q;
    h_d   = h_q;
    v_d   = v_q;
    if (!run) begin
      div_d = '0;
      h_d   = '0;
      v_d   = '0;
    end else begin
      div_d = pce ? '0 : div_q + 1'b1;
      if (pce) begin
        if (h_q == H_LAST) begin
          h_d = '0;
          v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
        end else begin
          h_d = h_q + 10'd1;
        end
      end
    end
  end

  always_ff @(posedge clock_in) begin
    if (!reset) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
    end
  end

  assign line_start  = pce && (h_q == 10'd0);
  assign frame_start = line_start && (v_q == 10'd0);

  assign vga.pixel_ce    = pce;
  assign vga.hcount      = h_q;
  assign vga.vcount      = v_q;
  assign vga.line_start  = line_start;
  assign vga.frame_start = frame_start;
  assign vga.active      = run && ({1'b0, h_q} < H_VIS) && ({1'b0, v_q} < V_VIS);
  assign vga.hsync = (run && ({1'b0, h_q} >= HS_START) && ({1'b0, h_q} < HS_END))
                     ? SYNC_ON : ~SYNC_ON;
  assign vga.vsync = (run && ({1'b0, v_q} >= VS_START) && ({1'b0, v_q} < VS_END))
                     ? SYNC_ON : ~SYNC_ON;

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [7:0] fcnt_q, fcnt_d;

  always_comb begin
    fcnt_d = fcnt_q;
    if (!run)             fcnt_d = '0;
    else if (frame_start) fcnt_d = fcnt_q + 8'd1;
  end

  always_ff @(posedge clock_in) begin
    if (!reset) fcnt_q <= '0;
    else        fcnt_q <= fcnt_d;
  end

  assign vga.frame_count = fcnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a small-geometry instance for frame-level timing
// and a default-geometry instance for one full 640x480 line.
module tb_vga_timing_gen;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic pll = 1'b1;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  // Small geometry: H_TOTAL=25 (sync 18..21), V_TOTAL=15 (sync 10..11)
  vga_timing_gen_if s_if ();
  vga_timing_gen #(
    .CLK_DIV(4), .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
    .V_VISIBLE(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .SYNC_POL(0)
  ) u_small (
    .clock_in(clk), .reset(rst), .pll_locked(pll), .vga(s_if)
  );

  vga_timing_gen_if d_if ();
  vga_timing_gen u_dflt (
    .clock_in(clk), .reset(rst), .pll_locked(pll), .vga(d_if)
  );

  typedef struct {
    logic       rst;
    logic       pll;
    logic       pce;
    logic [9:0] h;
    logic [9:0] v;
    logic       hs;
    logic       vs;
    logic       act;
    logic       ls;
    logic       fs;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_s_hv(input logic [9:0] h, input logic [9:0] v, input string name);
    int k = 0;
    while (!(s_if.hcount == h && s_if.vcount == v) && k < 3000) begin
      tick();
      k++;
    end
    chk({name, "_reached"}, 32'(k < 3000), 32'd1);
  endtask

  task automatic wait_fs(input bit dflt, input string name);
    int k = 0;
    while (!(dflt ? d_if.frame_start : s_if.frame_start) && k < 3000) begin
      tick();
      k++;
    end
    chk({name, "_reached"}, 32'(k < 3000), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pce_n, ls_n, fs_n, hs_lo, vs_lo, act_n;
    int hs_min, hs_max, vs_min, vs_max, inact_hmin, act_vmax;

    // Reset held 5 clocks, then release and follow the startup cycle by cycle
    for (int i = 0; i < 5; i++) tbl[i] = '{1'b0, 1'b1, 1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[7]  = tbl[6];
    tbl[8]  = tbl[6];
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 10; i < 13; i++) tbl[i] = '{1'b1, 1'b1, 1'b0, 10'd1, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 1'b1, 1'b1, 10'd1, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    for (int i = 0; i < 14; i++) begin
      rst = tbl[i].rst;
      pll = tbl[i].pll;
      tick();
      chk($sformatf("vec%0d_pce", i), 32'(s_if.pixel_ce), 32'(tbl[i].pce));
      chk($sformatf("vec%0d_h", i), 32'(s_if.hcount), 32'(tbl[i].h));
      chk($sformatf("vec%0d_v", i), 32'(s_if.vcount), 32'(tbl[i].v));
      chk($sformatf("vec%0d_hs", i), 32'(s_if.hsync), 32'(tbl[i].hs));
      chk($sformatf("vec%0d_vs", i), 32'(s_if.vsync), 32'(tbl[i].vs));
      chk($sformatf("vec%0d_act", i), 32'(s_if.active), 32'(tbl[i].act));
      chk($sformatf("vec%0d_ls", i), 32'(s_if.line_start), 32'(tbl[i].ls));
      chk($sformatf("vec%0d_fs", i), 32'(s_if.frame_start), 32'(tbl[i].fs));
      chk($sformatf("vec%0d_dflt_pce", i), 32'(d_if.pixel_ce), 32'(tbl[i].pce));
    end

    // One full small frame (1500 clocks) starting from a frame_start cycle
    wait_fs(1'b0, "frame_a");
`ifdef VGA_TIMING_FRAME_CNT_EN
    chk("fcnt_second_frame", 32'(s_if.frame_count), 32'd1);
`endif
    pce_n = 0; ls_n = 0; fs_n = 0; hs_lo = 0; vs_lo = 0; act_n = 0;
    hs_min = 1023; hs_max = 0; vs_min = 1023; vs_max = 0; inact_hmin = 1023; act_vmax = 0;
    for (int k = 1; k <= 1500; k++) begin
      tick();
      pce_n += int'(s_if.pixel_ce);
      ls_n  += int'(s_if.line_start);
      fs_n  += int'(s_if.frame_start);
      act_n += int'(s_if.active);
      if (!s_if.hsync) begin
        hs_lo++;
        if (int'(s_if.hcount) < hs_min) hs_min = int'(s_if.hcount);
        if (int'(s_if.hcount) > hs_max) hs_max = int'(s_if.hcount);
      end
      if (!s_if.vsync) begin
        vs_lo++;
        if (int'(s_if.vcount) < vs_min) vs_min = int'(s_if.vcount);
        if (int'(s_if.vcount) > vs_max) vs_max = int'(s_if.vcount);
      end
      if (!s_if.active && s_if.vcount < 10'd8 && int'(s_if.hcount) < inact_hmin) inact_hmin = int'(s_if.hcount);
      if (s_if.active && int'(s_if.vcount) > act_vmax) act_vmax = int'(s_if.vcount);
      if (k == 96) begin
        chk("line_end_h", 32'(s_if.hcount), 32'd24);
        chk("line_end_v", 32'(s_if.vcount), 32'd0);
      end
      if (k == 100) begin
        chk("line_wrap_h", 32'(s_if.hcount), 32'd0);
        chk("line_wrap_v", 32'(s_if.vcount), 32'd1);
        chk("line_wrap_ls", 32'(s_if.line_start), 32'd1);
        chk("line_wrap_fs", 32'(s_if.frame_start), 32'd0);
      end
      if (k == 1496) begin
        chk("frame_end_h", 32'(s_if.hcount), 32'd24);
        chk("frame_end_v", 32'(s_if.vcount), 32'd14);
      end
      if (k == 1500) begin
        chk("frame_wrap_v", 32'(s_if.vcount), 32'd0);
        chk("frame_wrap_fs", 32'(s_if.frame_start), 32'd1);
      end
    end
    chk("frame_pce_count", 32'(pce_n), 32'd375);
    chk("frame_ls_count", 32'(ls_n), 32'd15);
    chk("frame_fs_count", 32'(fs_n), 32'd1);
    chk("frame_active_clks", 32'(act_n), 32'd512);
    chk("frame_hsync_clks", 32'(hs_lo), 32'd240);
    chk("frame_vsync_clks", 32'(vs_lo), 32'd200);
    chk("hsync_first_h", 32'(hs_min), 32'd18);
    chk("hsync_last_h", 32'(hs_max), 32'd21);
    chk("vsync_first_v", 32'(vs_min), 32'd10);
    chk("vsync_last_v", 32'(vs_max), 32'd11);
    chk("blank_first_h", 32'(inact_hmin), 32'd16);
    chk("active_last_v", 32'(act_vmax), 32'd7);

    // Lock loss mid-frame, then relock
    wait_s_hv(10'd10, 10'd5, "drop_point");
    pll = 1'b0;
    tick();
    tick();
    chk("drop2_active", 32'(s_if.active), 32'd0);
    tick();
    chk("drop3_h", 32'(s_if.hcount), 32'd0);
    chk("drop3_v", 32'(s_if.vcount), 32'd0);
    chk("drop3_hs", 32'(s_if.hsync), 32'd1);
    chk("drop3_vs", 32'(s_if.vsync), 32'd1);
    chk("drop3_pce", 32'(s_if.pixel_ce), 32'd0);
    repeat (5) tick();
    chk("drop_hold_h", 32'(s_if.hcount), 32'd0);
    chk("drop_hold_act", 32'(s_if.active), 32'd0);
    pll = 1'b1;
    repeat (4) tick();
    chk("relock4_pce", 32'(s_if.pixel_ce), 32'd0);
    tick();
    chk("relock5_pce", 32'(s_if.pixel_ce), 32'd1);
    chk("relock5_fs", 32'(s_if.frame_start), 32'd1);
    chk("relock5_h", 32'(s_if.hcount), 32'd0);

    // Single-clock reset inside the vertical sync region, lock held
    wait_s_hv(10'd20, 10'd10, "rst_point");
    chk("pre_rst_vsync", 32'(s_if.vsync), 32'd0);
    rst = 1'b0;
    tick();
    chk("rst_h", 32'(s_if.hcount), 32'd0);
    chk("rst_v", 32'(s_if.vcount), 32'd0);
    chk("rst_vsync", 32'(s_if.vsync), 32'd1);
    chk("rst_active", 32'(s_if.active), 32'd0);
`ifdef VGA_TIMING_FRAME_CNT_EN
    chk("rst_fcnt", 32'(s_if.frame_count), 32'd0);
`endif
    rst = 1'b1;
    tick();
    chk("rel1_active", 32'(s_if.active), 32'd0);
    tick();
    chk("rel2_active", 32'(s_if.active), 32'd1);
    repeat (2) tick();
    chk("rel4_pce", 32'(s_if.pixel_ce), 32'd0);
    tick();
    chk("rel5_fs", 32'(s_if.frame_start), 32'd1);

    // One full 640x480 line on the default-geometry instance
    wait_fs(1'b1, "dflt_line");
    pce_n = 0; hs_lo = 0; act_n = 0; hs_min = 1023; hs_max = 0; inact_hmin = 1023;
    for (int k = 1; k <= 3200; k++) begin
      tick();
      pce_n += int'(d_if.pixel_ce);
      act_n += int'(d_if.active);
      if (!d_if.hsync) begin
        hs_lo++;
        if (int'(d_if.hcount) < hs_min) hs_min = int'(d_if.hcount);
        if (int'(d_if.hcount) > hs_max) hs_max = int'(d_if.hcount);
      end
      if (!d_if.active && d_if.vcount == 10'd0 && int'(d_if.hcount) < inact_hmin) inact_hmin = int'(d_if.hcount);
      if (k == 3196) begin
        chk("dflt_end_h", 32'(d_if.hcount), 32'd799);
        chk("dflt_end_v", 32'(d_if.vcount), 32'd0);
      end
      if (k == 3200) begin
        chk("dflt_wrap_h", 32'(d_if.hcount), 32'd0);
        chk("dflt_wrap_v", 32'(d_if.vcount), 32'd1);
        chk("dflt_wrap_ls", 32'(d_if.line_start), 32'd1);
      end
    end
    chk("dflt_pce_count", 32'(pce_n), 32'd800);
    chk("dflt_active_clks", 32'(act_n), 32'd2560);
    chk("dflt_hsync_clks", 32'(hs_lo), 32'd384);
    chk("dflt_hsync_first", 32'(hs_min), 32'd656);
    chk("dflt_hsync_last", 32'(hs_max), 32'd751);
    chk("dflt_blank_first", 32'(inact_hmin), 32'd640);
    chk("dflt_vsync_idle", 32'(d_if.vsync), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Consumes the ~100.5 MHz PLL output clock and its lock flag.
- Divides by CLK_DIV to produce a ~25.125 MHz pixel clock-enable.
- Generates 640x480@60 VGA horizontal/vertical counters, syncs, blanking and frame/line strobes.
- Sits directly downstream of the PLL wrapper and feeds the VGA pixel/framebuffer stage.

Parameters:
CLK_DIV, 4, clock_in cycles per pixel (>=2)
H_VISIBLE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_VISIBLE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BACK, 33, vertical back porch (lines)
SYNC_POL, 0, sync active level (0 = active-low)

Ports:
clock_in  input  1  PLL output clock; sole clock
reset  input  1  synchronous, active-low reset
pll_locked  input  1  PLL lock flag; asynchronous to nothing but may glitch
pixel_ce  output  1  one-clock pulse every CLK_DIV clocks while running
hcount  output  10  current pixel column, 0..H_TOTAL-1
vcount  output  10  current line, 0..V_TOTAL-1
hsync  output  1  horizontal sync
vsync  output  1  vertical sync
active  output  1  high when in visible region
line_start  output  1  pulse: pixel_ce && hcount==0
frame_start  output  1  pulse: pixel_ce && hcount==0 && vcount==0

Behaviour:
- Clock and reset: one clock (clock_in). Reset is synchronous and active-low; reset==0 is sampled on the rising edge of clock_in.
- Totals:
  - H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800).
  - V_TOTAL = V_VISIBLE+V_FRONT+V_SYNC+V_BACK (525).
  - Both totals must be <=1024; this is an elaboration-time check.
- Lock synchronizer: 2-flop synchronizer on pll_locked. Its output is run.
  - run rises 2 clocks after pll_locked rises.
  - run falls 2 clocks after pll_locked falls.
- Reset or run==0 forces, on the next edge:
  - div_cnt=0, hcount=0, vcount=0.
  - Synchronizer flops are cleared by reset only.
- Output values while reset is asserted or run==0: pixel_ce=0, line_start=0, frame_start=0, active=0, hsync=vsync=~SYNC_POL.
- Divider: div_cnt counts 0..CLK_DIV-1 while run=1. pixel_ce = run && div_cnt==CLK_DIV-1. The first pixel_ce occurs on the CLK_DIV-th clock after run goes high.
- Counters:
  - On an edge with pixel_ce=1, hcount increments. At H_TOTAL-1 it wraps to 0 and vcount increments.
  - vcount wraps from V_TOTAL-1 to 0 when hcount also wraps.
  - Each (hcount,vcount) pair is held for exactly CLK_DIV clocks.
- Decode: combinational from the registered counters (zero latency), gated by run.
  - active = hcount<H_VISIBLE && vcount<V_VISIBLE.
  - hsync = SYNC_POL when H_VISIBLE+H_FRONT <= hcount < H_VISIBLE+H_FRONT+H_SYNC (656..751), else ~SYNC_POL.
  - vsync = SYNC_POL when V_VISIBLE+V_FRONT <= vcount < V_VISIBLE+V_FRONT+V_SYNC (490..491), else ~SYNC_POL.
- Strobes: line_start and frame_start are high only in the clock_in cycle where pixel_ce is high, i.e. the last clock of pixel 0.
- Lock loss mid-frame: within 3 clocks of pll_locked falling, all outputs are at their reset values. On relock, timing restarts at (0,0), and the first pixel_ce produces frame_start.
- Simultaneous reset and pll_locked rising: reset wins; the synchronizer stays cleared.

Optional Feature:
- Macro: VGA_TIMING_FRAME_CNT_EN
- When defined:
  - Adds output frame_count (8 bits).
  - Reset value 0; it is also cleared when run==0.
  - Increments on every frame_start pulse, wrapping 255->0.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Hold reset=0 for 5 clocks with pll_locked=1 -> hcount=vcount=0, pixel_ce=0, active=0, hsync=vsync=1, line_start=frame_start=0.
- Release reset with pll_locked=1 -> run after 2 clocks; first pixel_ce 4 clocks later; then pixel_ce exactly every 4th clock; active=1 at (0,0); frame_start pulses with the first pixel_ce.
- Run one line -> line period 3200 clocks; active low from hcount=640; hsync low for hcount 656..751 (384 clocks); hcount wraps 799->0 and vcount 0->1.
- Run one full frame -> frame period 1,680,000 clocks; vsync low for vcount 490..491 (6400 clocks); exactly one frame_start; vcount wraps 524->0.
- Drop pll_locked at (300,100) -> by 3 clocks counters=0, syncs high, active=0. Reassert -> restart at (0,0) with frame_start.
- Assert reset for 1 clock at (700,495) with pll_locked held -> next edge counters=0 and vsync high; run resumes 2 clocks after release. With VGA_TIMING_FRAME_CNT_EN: after 3 frames frame_count=3, and 0 after reset.
